// File: rtl/if_stage_pkg.sv
// Shared widths, the NOP encoding and fetch-mode decode for the fetch stage.
package if_stage_pkg;

    localparam int INST_W  = 32;
    localparam int ADDR_W  = 64;
    localparam int BLOCK_W = 64;

    localparam logic [INST_W-1:0] NOP_INST = 32'h47FF041F;

    // How many instructions leave the fetch stage this cycle.
    typedef enum logic [1:0] {
        MODE_STALL = 2'd0,  // nothing delivered, PC holds
        MODE_ONE   = 2'd1,  // slot A only, PC advances one word
        MODE_TWO   = 2'd2   // slots A and B, PC advances one block
    } fetch_mode_e;

    // A full stall wins over a single-issue limit. A PC in the upper half of
    // the block can only deliver one word because fetch never spans blocks.
    function automatic fetch_mode_e fetch_mode(input logic stall,
                                               input logic one_only,
                                               input logic upper_half);
        if (stall)
            return MODE_STALL;
        else if (one_only || upper_half)
            return MODE_ONE;
        else
            return MODE_TWO;
    endfunction

endpackage

// File: rtl/if_inst_select.sv
// Combinational slot selection, valid generation, NOP insertion and PC step.
module if_inst_select
    import if_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = if_stage_pkg::NOP_INST
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [BLOCK_W-1:0] block_data,
    input  logic               stall,
    input  logic               one_only,
    output logic [INST_W-1:0]  ir_a,
    output logic [INST_W-1:0]  ir_b,
    output logic               valid_a,
    output logic               valid_b,
    output logic [ADDR_W-1:0]  next_pc
);

    fetch_mode_e mode;

    // Pick the words for each slot and the PC successor from the fetch mode.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        mode    = fetch_mode(stall, one_only, pc[2]);
        ir_a    = NOP_INST;
        ir_b    = NOP_INST;
        valid_a = 1'b0;
        valid_b = 1'b0;
        next_pc = pc;

        case (mode)
            MODE_ONE: begin
                valid_a = 1'b1;
                next_pc = pc + 64'd4;
            end
            MODE_TWO: begin
                valid_a = 1'b1;
                valid_b = 1'b1;
                next_pc = pc + 64'd8;
            end
            default: ;
        endcase

        // Slot A is the word the PC points at; slot B is always the upper word.
        if (valid_a)
            ir_a = pc[2] ? block_data[63:32] : block_data[31:0];
        if (valid_b)
            ir_b = block_data[63:32];
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: holds the fetch PC and presents up to two words.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter logic [INST_W-1:0] NOP_INST = if_stage_pkg::NOP_INST
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] Imem2proc_data,
    input  logic               non_ins_en_in,
    input  logic               one_ins_en_in,
    output logic [ADDR_W-1:0]  proc2Imem_addr,
    output logic [INST_W-1:0]  if_IRA_out,
    output logic [INST_W-1:0]  if_IRB_out,
    output logic               if_valid_instA_out,
    output logic               if_valid_instB_out
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] next_pc;

    // Memory is addressed by whole 8-byte blocks.
    assign proc2Imem_addr = {pc_reg[ADDR_W-1:3], 3'b000};

    // Reset is treated as a stall so nothing is delivered while it is held.
    if_inst_select #(
        .NOP_INST (NOP_INST)
    ) u_select (
        .pc         (pc_reg),
        .block_data (Imem2proc_data),
        .stall      (reset | non_ins_en_in),
        .one_only   (one_ins_en_in),
        .ir_a       (if_IRA_out),
        .ir_b       (if_IRB_out),
        .valid_a    (if_valid_instA_out),
        .valid_b    (if_valid_instB_out),
        .next_pc    (next_pc)
    );

    // Fetch PC register, forced to RESET_PC asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment to avoid races.
        if (reset)
            pc_reg <= RESET_PC;
        else
            pc_reg <= next_pc;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h47FF041F;
    localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFF0;

    logic        clock;
    logic        reset;
    logic [63:0] Imem2proc_data;
    logic        non_ins_en_in;
    logic        one_ins_en_in;

    logic [63:0] addr,  w_addr;
    logic [31:0] ira,   irb,   w_ira, w_irb;
    logic        va,    vb,    w_va,  w_vb;

    int tests  = 0;
    int failed = 0;

    if_stage dut (
        .clock              (clock),
        .reset              (reset),
        .Imem2proc_data     (Imem2proc_data),
        .non_ins_en_in      (non_ins_en_in),
        .one_ins_en_in      (one_ins_en_in),
        .proc2Imem_addr     (addr),
        .if_IRA_out         (ira),
        .if_IRB_out         (irb),
        .if_valid_instA_out (va),
        .if_valid_instB_out (vb)
    );

    // Second instance starting near the top of the address space for wrap.
    if_stage #(.RESET_PC(WRAP)) dut_wrap (
        .clock              (clock),
        .reset              (reset),
        .Imem2proc_data     (Imem2proc_data),
        .non_ins_en_in      (non_ins_en_in),
        .one_ins_en_in      (one_ins_en_in),
        .proc2Imem_addr     (w_addr),
        .if_IRA_out         (w_ira),
        .if_IRB_out         (w_irb),
        .if_valid_instA_out (w_va),
        .if_valid_instB_out (w_vb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_slots(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                               input logic eva, input logic evb);
        check({tag, ".ira"}, 64'(ira), 64'(ea));
        check({tag, ".irb"}, 64'(irb), 64'(eb));
        check({tag, ".va"},  64'(va),  64'(eva));
        check({tag, ".vb"},  64'(vb),  64'(evb));
    endtask

    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    initial begin
        // Reset held, single-issue request, all-ones memory.
        reset          = 1'b1;
        Imem2proc_data = 64'hFFFF_FFFF_FFFF_FFFF;
        non_ins_en_in  = 1'b0;
        one_ins_en_in  = 1'b1;
        #2;
        check("rst.addr", addr, 64'h0);
        check("rst.pc", dut.pc_reg, 64'h0);
        check_slots("rst", NOP, NOP, 1'b0, 1'b0);
        next_cycle();
        check_slots("rst_hold", NOP, NOP, 1'b0, 1'b0);

        // Release: single-issue stepping 0 -> 4 -> 8.
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_slots("one.c1", 32'hFFFF_FFFF, NOP, 1'b1, 1'b0);
        check("one.c1.addr", addr, 64'h0);
        next_cycle();
        check("one.pc4", dut.pc_reg, 64'd4);
        check("one.addr4", addr, 64'h0);
        check_slots("one.c2", 32'hFFFF_FFFF, NOP, 1'b1, 1'b0);
        next_cycle();
        check("one.pc8", dut.pc_reg, 64'd8);
        check("one.addr8", addr, 64'd8);

        // Back to 0, then two-wide fetch stepping 0 -> 8 -> 16.
        reset          = 1'b1;
        Imem2proc_data = 64'h2222_2222_1111_1111;
        one_ins_en_in  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("two.pc0", dut.pc_reg, 64'h0);
        check_slots("two.c0", 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1);
        next_cycle();
        check("two.pc8", dut.pc_reg, 64'd8);
        check("two.addr8", addr, 64'd8);
        check_slots("two.c1", 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1);
        next_cycle();
        check("two.pc16", dut.pc_reg, 64'd16);
        check("two.addr16", addr, 64'd16);

        // Asynchronous reset between edges at PC=16.
        reset = 1'b1;
        #1;
        check("async.pc", dut.pc_reg, 64'h0);
        check("async.addr", addr, 64'h0);
        check_slots("async", NOP, NOP, 1'b0, 1'b0);

        // Run one two-wide cycle to PC=8, then stall three cycles.
        @(negedge clock);
        reset = 1'b0;
        next_cycle();
        check("pre_stall.pc", dut.pc_reg, 64'd8);
        non_ins_en_in = 1'b1;
        one_ins_en_in = 1'b1;
        #1;
        check_slots("stall.c0", NOP, NOP, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check($sformatf("stall.pc%0d", i), dut.pc_reg, 64'd8);
            check($sformatf("stall.addr%0d", i), addr, 64'd8);
            check($sformatf("stall.va%0d", i), 64'(va), 64'h0);
            check($sformatf("stall.vb%0d", i), 64'(vb), 64'h0);
        end

        // Reach PC=4 via one single-issue step, then two-wide request at PC=4.
        non_ins_en_in = 1'b0;
        reset         = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        next_cycle();
        check("odd.pc4", dut.pc_reg, 64'd4);
        one_ins_en_in = 1'b0;
        #1;
        check_slots("odd", 32'h2222_2222, NOP, 1'b1, 1'b0);
        check("odd.addr", addr, 64'h0);
        next_cycle();
        check("odd.next", dut.pc_reg, 64'd8);

        // Wrap-around on the high-reset instance: F0 -> F8 -> 0.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("wrap.addr0", w_addr, WRAP);
        check("wrap.va", 64'(w_va), 64'h1);
        check("wrap.vb", 64'(w_vb), 64'h1);
        check("wrap.ira", 64'(w_ira), 64'h1111_1111);
        next_cycle();
        check("wrap.addr1", w_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        check("wrap.irb", 64'(w_irb), 64'h2222_2222);
        next_cycle();
        check("wrap.addr2", w_addr, 64'h0);
        check("wrap.pc2", dut_wrap.pc_reg, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0: fetch PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h47FF041F: instruction word driven on any invalid slot.
REQ-003 Single clock; reset asynchronous, active-high.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 Imem2proc_data  input  64  aligned 8-byte fetch block from instruction memory; [31:0] = word at addr, [63:32] = word at addr+4.
REQ-007 non_ins_en_in  input  1  downstream accepts no instruction this cycle (full stall).
REQ-008 one_ins_en_in  input  1  downstream accepts at most one instruction this cycle.
REQ-009 proc2Imem_addr  output  64  fetch address, 8-byte aligned.
REQ-010 if_IRA_out  output  32  first (older) fetched instruction.
REQ-011 if_IRB_out  output  32  second (younger) fetched instruction.
REQ-012 if_valid_instA_out  output  1  slot A holds a valid instruction.
REQ-013 if_valid_instB_out  output  1  slot B holds a valid instruction.

Function
REQ-014 Internal 64-bit PC_reg is the address of the next instruction to deliver; next_PC is its combinational successor.
REQ-015 proc2Imem_addr SHALL equal {PC_reg[63:3], 3'b000}, combinational from PC_reg.
REQ-016 Imem2proc_data is combinational; outputs reflect it in the same cycle (zero latency).
REQ-017 PC_reg[2]=0: IRA = data[31:0], IRB = data[63:32]; both slots available.
REQ-018 PC_reg[2]=1: IRA = data[63:32]; slot B unavailable (no crossing of the 8-byte block).
REQ-019 Mode priority: non_ins_en_in over one_ins_en_in over normal two-wide.
REQ-020 non_ins_en_in=1: both valids 0, next_PC = PC_reg.
REQ-021 one_ins_en_in=1 (non_ins_en_in=0): validA=1, validB=0, next_PC = PC_reg+4.
REQ-022 Both enables 0, PC_reg[2]=0: validA=validB=1, next_PC = PC_reg+8.
REQ-023 Both enables 0, PC_reg[2]=1: validA=1, validB=0, next_PC = PC_reg+4.
REQ-024 Any slot with valid=0 drives NOP_INST on its IR output.
REQ-025 PC_reg <= next_PC on each rising clock edge while reset=0.
REQ-026 PC arithmetic is 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFF8 + 8 wraps to 0.
REQ-027 No branch redirect input; fetch is strictly sequential.

Reset
REQ-028 reset=1 asynchronously sets PC_reg = RESET_PC, independent of clock.
REQ-029 While reset=1: both valids 0, both IR outputs NOP_INST, proc2Imem_addr = aligned RESET_PC.
REQ-030 Reset asserted mid-operation discards in-flight fetch; first cycle after release delivers from RESET_PC.

Structure
REQ-031 Shared package holds NOP_INST, instruction width (32), address width (64) and fetch-block width (64).
REQ-032 One natural sub-module, if_inst_select: combinational slot selection, valids, NOP insertion and PC increment; if_stage holds PC_reg only.

Verification
REQ-033 reset=1, data=64'hFFFF_FFFF_FFFF_FFFF, one_ins_en_in=1 -> addr=0, validA=validB=0, IRA=IRB=32'h47FF041F.
REQ-034 Release reset (same stimulus) -> cycle 1: IRA=32'hFFFFFFFF, validA=1, validB=0, IRB=NOP; next edge PC_reg=4, addr=0; next: PC_reg=8, addr=8.
REQ-035 Both enables 0, data=64'h22222222_11111111, PC=0 -> IRA=32'h11111111, IRB=32'h22222222, both valid; PC steps 0,8,16.
REQ-036 non_ins_en_in=1 for 3 cycles with one_ins_en_in=1 -> valids 0, PC_reg unchanged, addr stable.
REQ-037 PC=4 with both enables 0, data=64'h22222222_11111111 -> IRA=32'h22222222, validA=1, validB=0, next PC=8.
REQ-038 Assert reset between clock edges at PC=16 -> PC_reg=0 immediately, valids 0 before the next edge.
